// File: rtl/rv32i_pkg.sv
// Purpose: shared RV32I opcode/format types and per-format field packers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: XLEN/FMT_W, opcode_e (shared with decoder), fmt_e, F3_ADDI, pack_* helpers.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int FMT_W = 4;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  localparam logic [2:0] F3_ADDI = 3'b000;

  // Values 10..15 are unsupported and flagged as illegal by the encoder.
  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 4'd0,
    FMT_I_LOAD  = 4'd1,
    FMT_I_ALU   = 4'd2,
    FMT_S       = 4'd3,
    FMT_B       = 4'd4,
    FMT_U_AUIPC = 4'd5,
    FMT_U_LUI   = 4'd6,
    FMT_JALR    = 4'd7,
    FMT_JAL     = 4'd8,
    FMT_LI      = 4'd9
  } fmt_e;

  // Immediate arguments take exactly the bit range each format stores, so
  // callers make the discarded bits explicit at the call site.
  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input opcode_e op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input opcode_e op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input opcode_e op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input opcode_e op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:12] imm, input logic [4:0] rd,
                                         input opcode_e op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                         input opcode_e op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/rv32i_encoder_if.sv
// Purpose: request/response stream bundle of the RV32I encoder.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready request side, out_valid/out_ready word side.
// Ports: master = request source / word sink; slave = encoder.
interface rv32i_encoder_if;
  import rv32i_pkg::*;

  logic            in_valid;
  logic            in_ready;
  fmt_e            in_fmt;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_last;
  logic            err_illegal;

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, err_illegal
  );

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, err_illegal
  );

endinterface

// File: rtl/rv32i_field_pack.sv
// Purpose: combinational fields->instruction word packer, incl. LI hi/lo split.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
// Ports: i_fmt/i_rd/i_rs1/i_rs2/i_funct3/i_funct7/i_imm in; o_legal, o_two
//        (LI needs LUI+ADDI), o_word (first word), o_second (ADDI of a pair).
// Config: RV32I_ENCODER_LI_EXPAND_EN enables LI; otherwise FMT_LI is illegal.
module rv32i_field_pack
  import rv32i_pkg::*;
(
  input  fmt_e            i_fmt,
  input  logic [4:0]      i_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_legal,
  output logic            o_two,
  output logic [31:0]     o_word,
  output logic [31:0]     o_second
);

`ifdef RV32I_ENCODER_LI_EXPAND_EN
  // ADDI sign-extends lo, so hi is rounded up whenever lo[11] is set.
  logic [19:0] w_li_hi;
  logic [11:0] w_li_lo;
  logic [31:0] w_li_lui;
  logic [31:0] w_li_addi_rd;
  logic [31:0] w_li_addi_x0;

  assign w_li_hi      = i_imm[31:12] + {19'd0, i_imm[11]};
  assign w_li_lo      = i_imm[11:0];
  assign w_li_lui     = pack_u(w_li_hi, i_rd, OP_LUI);
  assign w_li_addi_rd = pack_i(w_li_lo, i_rd, F3_ADDI, i_rd, OP_IMM);
  assign w_li_addi_x0 = pack_i(w_li_lo, 5'd0, F3_ADDI, i_rd, OP_IMM);
`endif

  always_comb begin
    o_legal  = 1'b1;
    o_two    = 1'b0;
    o_word   = '0;
    o_second = '0;
    case (i_fmt)
      FMT_R:       o_word = pack_r(i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_OP);
      FMT_I_LOAD:  o_word = pack_i(i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD);
      FMT_I_ALU:   o_word = pack_i(i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM);
      FMT_S:       o_word = pack_s(i_imm[11:0], i_rs2, i_rs1, i_funct3, OP_STORE);
      FMT_B:       o_word = pack_b(i_imm[12:1], i_rs2, i_rs1, i_funct3, OP_BRANCH);
      FMT_U_AUIPC: o_word = pack_u(i_imm[31:12], i_rd, OP_AUIPC);
      FMT_U_LUI:   o_word = pack_u(i_imm[31:12], i_rd, OP_LUI);
      FMT_JALR:    o_word = pack_i(i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR);
      FMT_JAL:     o_word = pack_j(i_imm[20:1], i_rd, OP_JAL);
      FMT_LI: begin
`ifdef RV32I_ENCODER_LI_EXPAND_EN
        if (w_li_hi == '0) begin
          o_word = w_li_addi_x0;
        end else if (w_li_lo == '0) begin
          o_word = w_li_lui;
        end else begin
          o_word   = w_li_lui;
          o_second = w_li_addi_rd;
          o_two    = 1'b1;
        end
`else
        o_legal = 1'b0;
`endif
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_encoder.sv
// Purpose: streaming RV32I instruction encoder (fields in, 32-bit words out).
// Latency: 1 cycle; each word is registered and valid the cycle after acceptance.
// Backpressure: in_ready = !out_valid || (out_ready && out_last); output held while stalled.
// Ports: clk, rst_n (async active-low), bus (rv32i_encoder_if.slave).
// Config: RV32I_ENCODER_LI_EXPAND_EN enables LI -> LUI+ADDI expansion.
module rv32i_encoder
  import rv32i_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  rv32i_encoder_if.slave bus
);

  // IDLE: nothing held. LAST: holding the final word. FIRST: holding the LUI
  // of an LI pair, with the ADDI parked in r_pending.
  typedef enum logic [1:0] {S_IDLE, S_LAST, S_FIRST} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_legal;
  logic        w_two;
  logic [31:0] w_word;
  logic [31:0] w_second;
  logic        w_accept;

  rv32i_field_pack u_pack (
    .i_fmt    (bus.in_fmt),
    .i_rd     (bus.in_rd),
    .i_rs1    (bus.in_rs1),
    .i_rs2    (bus.in_rs2),
    .i_funct3 (bus.in_funct3),
    .i_funct7 (bus.in_funct7),
    .i_imm    (bus.in_imm),
    .o_legal  (w_legal),
    .o_two    (w_two),
    .o_word   (w_word),
    .o_second (w_second)
  );

  assign bus.in_ready    = (r_state == S_IDLE) || ((r_state == S_LAST) && bus.out_ready);
  assign w_accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = (r_state != S_IDLE);
  assign bus.out_last    = (r_state == S_LAST);
  assign bus.out_instr   = r_instr;
  assign bus.err_illegal = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_instr   <= w_instr_nxt;
      r_pending <= w_pending_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_instr_nxt   = r_instr;
    w_pending_nxt = r_pending;
    w_err_nxt     = 1'b0;

    // Drain the held word first; an accepted request below overrides this.
    case (r_state)
      S_LAST: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      S_FIRST: begin
        if (bus.out_ready) begin
          w_state_nxt = S_LAST;
          w_instr_nxt = r_pending;
        end
      end
      default: w_state_nxt = r_state;
    endcase

    // Illegal requests are consumed without disturbing the output stage.
    if (w_accept) begin
      if (w_legal) begin
        w_instr_nxt   = w_word;
        w_pending_nxt = w_second;
        w_state_nxt   = w_two ? S_FIRST : S_LAST;
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_encoder.sv
module tb_rv32i_encoder;
  import rv32i_pkg::*;

  localparam logic [31:0] M_LOAD = 32'h03, M_IMM = 32'h13, M_AUIPC = 32'h17, M_STORE = 32'h23;
  localparam logic [31:0] M_OP = 32'h33, M_LUI = 32'h37, M_BRANCH = 32'h63;
  localparam logic [31:0] M_JALR = 32'h67, M_JAL = 32'h6F;

  logic clk;
  logic rst_n;
  rv32i_encoder_if bus ();

  rv32i_encoder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] expq[$];   // {last, word}
  logic [31:0] seen[$];   // every word the DUT handed over
  int seen_rd = 0;
  int err_seen = 0;
  logic err_exp = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int width, input int pos);
    logic [31:0] m;
    m = (32'd1 << width) - 32'd1;
    return (v & m) << pos;
  endfunction

  function automatic logic [31:0] itype(input logic [31:0] op, input logic [31:0] rd,
                                        input logic [31:0] f3, input logic [31:0] rs1,
                                        input logic [31:0] imm);
    return op | fld(rd, 5, 7) | fld(f3, 3, 12) | fld(rs1, 5, 15) | fld(imm, 12, 20);
  endfunction

  // Reference encoder: n words (0 = illegal request) built from field arithmetic.
  task automatic model(input fmt_e f, input logic [31:0] rd, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] f3, input logic [31:0] f7,
                       input logic [31:0] imm, output int n, output logic [31:0] w0,
                       output logic [31:0] w1);
    n = 1; w0 = '0; w1 = '0;
    case (f)
      FMT_R: w0 = M_OP | fld(rd, 5, 7) | fld(f3, 3, 12) | fld(rs1, 5, 15) | fld(rs2, 5, 20) | fld(f7, 7, 25);
      FMT_I_LOAD: w0 = itype(M_LOAD, rd, f3, rs1, imm);
      FMT_I_ALU:  w0 = itype(M_IMM, rd, f3, rs1, imm);
      FMT_JALR:   w0 = itype(M_JALR, rd, 32'd0, rs1, imm);
      FMT_S: w0 = M_STORE | fld(imm, 5, 7) | fld(f3, 3, 12) | fld(rs1, 5, 15) | fld(rs2, 5, 20) | fld(imm >> 5, 7, 25);
      FMT_B: w0 = M_BRANCH | fld(imm >> 11, 1, 7) | fld(imm >> 1, 4, 8) | fld(f3, 3, 12) | fld(rs1, 5, 15)
                | fld(rs2, 5, 20) | fld(imm >> 5, 6, 25) | fld(imm >> 12, 1, 31);
      FMT_U_LUI:   w0 = M_LUI | fld(rd, 5, 7) | (imm & 32'hFFFFF000);
      FMT_U_AUIPC: w0 = M_AUIPC | fld(rd, 5, 7) | (imm & 32'hFFFFF000);
      FMT_JAL: w0 = M_JAL | fld(rd, 5, 7) | fld(imm >> 12, 8, 12) | fld(imm >> 11, 1, 20)
                  | fld(imm >> 1, 10, 21) | fld(imm >> 20, 1, 31);
      FMT_LI: begin
`ifdef RV32I_ENCODER_LI_EXPAND_EN
        logic [31:0] hi;
        logic [31:0] lo;
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hFFF;
        if (hi == 0) begin
          w0 = itype(M_IMM, rd, 32'd0, 32'd0, lo);
        end else if (lo == 0) begin
          w0 = M_LUI | fld(rd, 5, 7) | (hi << 12);
        end else begin
          n  = 2;
          w0 = M_LUI | fld(rd, 5, 7) | (hi << 12);
          w1 = itype(M_IMM, rd, 32'd0, rd, lo);
        end
`else
        n = 0;
`endif
      end
      default: n = 0;
    endcase
  endtask

  // Compare process: every negedge, outputs vs model; then advance the model
  // with what the coming posedge will accept/consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk32("rst_out_instr", bus.out_instr, 32'h0);
      chk1("rst_out_last", bus.out_last, 1'b0);
      chk1("rst_err_illegal", bus.err_illegal, 1'b0);
      expq.delete();
      err_exp = 1'b0;
    end else begin
      int n;
      logic [31:0] w0, w1;
      chk1("in_ready", bus.in_ready,
           (expq.size() == 0) || ((expq.size() == 1) && bus.out_ready));
      chk1("out_valid", bus.out_valid, expq.size() != 0);
      if (bus.out_valid && expq.size() != 0) begin
        chk32("out_instr", bus.out_instr, expq[0][31:0]);
        chk1("out_last", bus.out_last, expq[0][32]);
      end
      chk1("err_illegal", bus.err_illegal, err_exp);
      if (bus.err_illegal) err_seen++;
      if (bus.out_valid && bus.out_ready) begin
        seen.push_back(bus.out_instr);
        if (expq.size() != 0) void'(expq.pop_front());
      end
      err_exp = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in_fmt, {27'd0, bus.in_rd}, {27'd0, bus.in_rs1}, {27'd0, bus.in_rs2},
              {29'd0, bus.in_funct3}, {25'd0, bus.in_funct7}, bus.in_imm, n, w0, w1);
        if (n == 0) err_exp = 1'b1;
        if (n == 1) expq.push_back({1'b1, w0});
        if (n == 2) begin
          expq.push_back({1'b0, w0});
          expq.push_back({1'b1, w1});
        end
      end
    end
  end

  task automatic send(input fmt_e f, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input logic [31:0] imm);
    bit done;
    int budget;
    bus.in_valid = 1'b1; bus.in_fmt = f; bus.in_rd = rd[4:0]; bus.in_rs1 = rs1[4:0];
    bus.in_rs2 = rs2[4:0]; bus.in_funct3 = f3[2:0]; bus.in_funct7 = f7[6:0]; bus.in_imm = imm;
    done = 1'b0;
    budget = 0;
    while (!done && budget < 50) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (expq.size() != 0 && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words still owed, required 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seen(input string name, input logic [31:0] e);
    if (seen_rd < seen.size()) begin
      chk32(name, seen[seen_rd], e);
      seen_rd++;
    end else begin
      checks++; errors++;
      $display("FAIL %s: no word emitted, required %h", name, e);
    end
  endtask

  initial begin
    int n_before;
    int e_before;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_fmt = FMT_R; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk32("reset_out_instr", bus.out_instr, 32'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Spec vectors, one at a time.
    send(FMT_R, 3, 1, 2, 0, 0, 32'h0);
    chk1("r_add_latency_valid", bus.out_valid, 1'b1);
    chk1("r_add_latency_last", bus.out_last, 1'b1);
    drain();
    expect_seen("r_add", 32'h002081B3);
    send(FMT_I_ALU, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    drain();
    expect_seen("i_alu_m1", 32'hFFF00093);
    send(FMT_JAL, 1, 0, 0, 0, 0, 32'h8);
    drain();
    expect_seen("jal_8", 32'h008000EF);

    // Back-to-back mix across every remaining format.
    send(FMT_S, 0, 1, 2, 2, 0, 32'h8);
    send(FMT_B, 0, 0, 0, 0, 0, 32'hFFFFFFFD);   // imm[0] set: must be dropped
    send(FMT_JALR, 0, 1, 0, 5, 0, 32'h0);       // funct3 forced to 000
    send(FMT_U_LUI, 2, 0, 0, 0, 0, 32'hABCDE123);
    send(FMT_I_LOAD, 5, 2, 0, 2, 0, 32'hFFFFFFFC);
    send(FMT_U_AUIPC, 1, 0, 0, 0, 0, 32'h1000);
    send(FMT_R, 3, 1, 2, 0, 32, 32'h0);
    drain();
    expect_seen("s_sw", 32'h0020A423);
    expect_seen("b_beq_m4", 32'hFE000EE3);
    expect_seen("jalr_ret", 32'h00008067);
    expect_seen("lui_lowbits", 32'hABCDE137);
    expect_seen("i_lw_m4", 32'hFFC12283);
    expect_seen("auipc", 32'h00001097);
    expect_seen("r_sub", 32'h402081B3);

    // Unsupported format: consumed, pulse, no word.
    e_before = err_seen;
    n_before = seen.size();
    send(fmt_e'(4'd12), 1, 1, 1, 0, 0, 32'h0);
    drain();
    chk32("illegal_err_pulses", err_seen, e_before + 1);
    chk32("illegal_no_word", seen.size(), n_before);

`ifdef RV32I_ENCODER_LI_EXPAND_EN
    bus.out_ready = 1'b0;
    send(FMT_LI, 5, 0, 0, 0, 0, 32'h12345FFF);
    repeat (3) @(posedge clk);
    #1;
    chk32("li_stall_instr", bus.out_instr, 32'h123462B7);
    chk1("li_stall_last", bus.out_last, 1'b0);
    bus.out_ready = 1'b1;
    drain();
    expect_seen("li_lui", 32'h123462B7);
    expect_seen("li_addi", 32'hFFF28293);
    send(FMT_LI, 1, 0, 0, 0, 0, 32'h800);
    send(FMT_LI, 1, 0, 0, 0, 0, 32'hFFFFF800);
    send(FMT_LI, 1, 0, 0, 0, 0, 32'h5000);
    send(FMT_LI, 1, 0, 0, 0, 0, 32'h0);
    drain();
    expect_seen("li_800_lui", 32'h000010B7);
    expect_seen("li_800_addi", 32'h80008093);
    expect_seen("li_hi_wrap", 32'h80000093);
    expect_seen("li_lo_zero", 32'h000050B7);
    expect_seen("li_zero", 32'h00000093);
    bus.out_ready = 1'b0;
    send(FMT_LI, 5, 0, 0, 0, 0, 32'h12345FFF);
`else
    e_before = err_seen;
    n_before = seen.size();
    send(FMT_LI, 5, 0, 0, 0, 0, 32'h12345FFF);
    drain();
    chk32("li_disabled_err", err_seen, e_before + 1);
    chk32("li_disabled_no_word", seen.size(), n_before);
    bus.out_ready = 1'b0;
    send(FMT_R, 3, 1, 2, 0, 0, 32'h0);
`endif

    // Reset while a word is held: outputs clear at once, nothing follows.
    n_before = seen.size();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", bus.out_valid, 1'b0);
    chk32("async_rst_instr", bus.out_instr, 32'h0);
    chk1("async_rst_last", bus.out_last, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk32("no_word_after_reset", seen.size(), n_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
